// File: rtl/vga_timing_sched_if.sv
// Line-fetch and pixel-source bus between the VGA timing scheduler (master)
// and the pixel source (slave).
interface vga_timing_sched_if;
    logic       line_req;
    logic [9:0] line_y;
    logic       line_ack;
    logic       pix_rd;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;

    modport master (
        output line_req, line_y, pix_rd,
        input  line_ack, pix_r, pix_g, pix_b
    );

    modport slave (
        input  line_req, line_y, pix_rd,
        output line_ack, pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/vga_timing_sched.sv
// VGA timing generator with per-line fetch scheduling, late-line detection
// and a fixed two-cycle pixel/sync output pipeline.
module vga_timing_sched #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic                       pixclk,
    input  logic                       rst_n,
    input  logic                       enable,
    vga_timing_sched_if.master         src,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic                       vga_blank,
    output logic [7:0]                 vga_r,
    output logic [7:0]                 vga_g,
    output logic [7:0]                 vga_b,
    output logic                       frame_start,
    output logic                       underflow,
    input  logic                       underflow_clr,
    output logic [9:0]                 beam_x,
    output logic [9:0]                 beam_y
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  HC_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0]  HC_LAST  = 10'(H_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VC_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0]  VC_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_req;
    logic [9:0]  r_line_y;
    logic        r_stop;
    logic        r_bad;
    logic        r_underflow;

    logic        r_blank_d1, r_hs_d1, r_vs_d1, r_rd_d1;
    logic        r_blank_d2, r_hs_d2, r_vs_d2;
    logic [7:0]  r_r_d2, r_g_d2, r_b_d2;

    logic        w_run;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_end;
    logic [9:0]  w_next_y;
    logic        w_slot;
    logic        w_new_req;
    logic        w_stop_set;
    logic        w_line_req;
    logic [9:0]  w_line_y;
    logic        w_miss;
    logic        w_active;
    logic        w_pix_rd;
    logic        w_hs_on;
    logic        w_vs_on;

    assign w_run       = (r_state == ST_RUN);
    assign w_h_last    = (r_hcnt == HC_LAST);
    assign w_v_last    = (r_vcnt == VC_LAST);
    assign w_frame_end = w_run && w_h_last && w_v_last;
    assign w_next_y    = w_v_last ? 10'd0 : r_vcnt + 10'd1;

    // The request for line y+1 goes out at the first blanking pixel of line y;
    // the wrap to line 0 is the only point where a stop can be taken.
    assign w_slot     = w_run && (r_hcnt == HC_VIS) && (w_next_y < VC_VIS);
    assign w_new_req  = w_slot && ((w_next_y != 10'd0) || enable);
    assign w_stop_set = w_slot && (w_next_y == 10'd0) && !enable;

    assign w_line_req = (r_state == ST_PRIME) || r_req || w_new_req;
    assign w_line_y   = r_req ? r_line_y : (w_new_req ? w_next_y : 10'd0);

    // An ack in the last cycle of the line still counts as on time.
    assign w_miss = w_run && (r_req || w_new_req) && w_h_last && !src.line_ack;

    assign w_active = w_run && (r_hcnt < HC_VIS) && (r_vcnt < VC_VIS);
    assign w_pix_rd = w_active && !r_bad;
    assign w_hs_on  = w_run && ({1'b0, r_hcnt} >= HS_START) && ({1'b0, r_hcnt} < HS_END);
    assign w_vs_on  = w_run && ({1'b0, r_vcnt} >= VS_START) && ({1'b0, r_vcnt} < VS_END);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable)                  w_state_next = ST_PRIME;
            ST_PRIME: if (src.line_ack)            w_state_next = ST_RUN;
            ST_RUN:   if (w_frame_end && r_stop)   w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_req       <= 1'b0;
            r_line_y    <= '0;
            r_stop      <= 1'b0;
            r_bad       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_run) begin
                r_hcnt <= w_h_last ? 10'd0 : r_hcnt + 10'd1;
                if (w_h_last) begin
                    r_vcnt <= w_next_y;
                end
            end else begin
                r_hcnt <= '0;
                r_vcnt <= '0;
            end

            r_req    <= w_run && (r_req || w_new_req) && !src.line_ack && !w_h_last;
            r_line_y <= w_line_y;

            if (w_frame_end && r_stop) begin
                r_stop <= 1'b0;
            end else if (w_stop_set) begin
                r_stop <= 1'b1;
            end

            // Badness is decided at the line boundary and held for the whole line.
            if (!w_run) begin
                r_bad <= 1'b0;
            end else if (w_h_last) begin
                r_bad <= w_miss;
            end

            if (w_miss) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Stage 1 tracks the counter cycle, stage 2 lines up with the pixel that
    // the source returns one cycle after pix_rd.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_d1 <= 1'b1;
            r_hs_d1    <= ~SYNC_ACTIVE;
            r_vs_d1    <= ~SYNC_ACTIVE;
            r_rd_d1    <= 1'b0;
            r_blank_d2 <= 1'b1;
            r_hs_d2    <= ~SYNC_ACTIVE;
            r_vs_d2    <= ~SYNC_ACTIVE;
            r_r_d2     <= '0;
            r_g_d2     <= '0;
            r_b_d2     <= '0;
        end else begin
            r_blank_d1 <= !w_active;
            r_hs_d1    <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs_d1    <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_rd_d1    <= w_pix_rd;
            r_blank_d2 <= r_blank_d1;
            r_hs_d2    <= r_hs_d1;
            r_vs_d2    <= r_vs_d1;
            r_r_d2     <= r_rd_d1 ? src.pix_r : 8'd0;
            r_g_d2     <= r_rd_d1 ? src.pix_g : 8'd0;
            r_b_d2     <= r_rd_d1 ? src.pix_b : 8'd0;
        end
    end

    assign src.line_req = w_line_req;
    assign src.line_y   = w_line_y;
    assign src.pix_rd   = w_pix_rd;

    assign vga_hsync   = r_hs_d2;
    assign vga_vsync   = r_vs_d2;
    assign vga_blank   = r_blank_d2;
    assign vga_r       = r_r_d2;
    assign vga_g       = r_g_d2;
    assign vga_b       = r_b_d2;
    assign frame_start = w_run && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    assign underflow   = r_underflow;
    assign beam_x      = r_hcnt;
    assign beam_y      = r_vcnt;

endmodule

// File: tb/tb_vga_timing_sched.sv
// Directed bench for vga_timing_sched on a shrunken 16x11 raster
// (8 visible pixels, 6 visible lines) so whole frames run quickly.
module tb_vga_timing_sched;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 16
    localparam int VT = VV + VF + VS + VB;   // 11

    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       underflow_clr;
    logic       vga_hsync, vga_vsync, vga_blank;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       frame_start, underflow;
    logic [9:0] beam_x, beam_y;

    vga_timing_sched_if bus ();

    vga_timing_sched #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .pixclk        (pixclk),
        .rst_n         (rst_n),
        .enable        (enable),
        .src           (bus.master),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_blank     (vga_blank),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .beam_x        (beam_x),
        .beam_y        (beam_y)
    );

    always #5 pixclk = ~pixclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Ack policy: 0 = ack after ack_delay cycles, 1 = never ack target_y,
    // 2 = ack target_y only in the last cycle of the line.
    int ack_mode  = 0;
    int ack_delay = 0;
    int target_y  = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(negedge pixclk);
    endtask

    task automatic wait_beam(input int x, input int y, input string tag);
        int n = 0;
        while (!((beam_x == 10'(x)) && (beam_y == 10'(y))) && n < 400) begin
            tick();
            n++;
        end
        check_value(tag, 32'((beam_x == 10'(x)) && (beam_y == 10'(y))), 32'd1);
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (!frame_start && n < 400) begin
            tick();
            n++;
        end
        check_value(tag, 32'(frame_start), 32'd1);
    endtask

    // Pixel source: returns a pattern keyed by the beam one cycle after pix_rd,
    // and junk otherwise so ungated data would show up on the outputs.
    initial begin
        logic       rd;
        logic [9:0] sx, sy;
        bus.pix_r = 8'hEE;
        bus.pix_g = 8'hEE;
        bus.pix_b = 8'hEE;
        forever begin
            @(negedge pixclk);
            #1;
            rd = bus.pix_rd;
            sx = beam_x;
            sy = beam_y;
            @(posedge pixclk);
            #1;
            bus.pix_r = rd ? (sx[7:0] + 8'h10) : 8'hEE;
            bus.pix_g = rd ? (sy[7:0] + 8'h20) : 8'hEE;
            bus.pix_b = rd ? 8'hA5 : 8'hEE;
        end
    end

    initial begin
        int wait_cnt = 0;
        bus.line_ack = 1'b0;
        forever begin
            @(negedge pixclk);
            #1;
            if (!bus.line_req) begin
                wait_cnt     = 0;
                bus.line_ack = 1'b0;
            end else begin
                case (ack_mode)
                    1:       bus.line_ack = (int'(bus.line_y) != target_y);
                    2:       bus.line_ack = (int'(bus.line_y) != target_y) || (int'(beam_x) == HT - 1);
                    default: bus.line_ack = (wait_cnt >= ack_delay);
                endcase
                wait_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, first_x, first_y, cnt, n_req, n_cyc, bad, bad_rd, bad_out;
        logic prev_req, seen;

        rst_n = 1'b0;
        enable = 1'b0;
        underflow_clr = 1'b0;

        // Reset values
        tick(); tick();
        check_value("rst_line_req", 32'(bus.line_req), 32'd0);
        check_value("rst_line_y",   32'(bus.line_y),   32'd0);
        check_value("rst_pix_rd",   32'(bus.pix_rd),   32'd0);
        check_value("rst_hsync",    32'(vga_hsync),    32'd1);
        check_value("rst_vsync",    32'(vga_vsync),    32'd1);
        check_value("rst_blank",    32'(vga_blank),    32'd1);
        check_value("rst_rgb",      {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        check_value("rst_frame_start", 32'(frame_start), 32'd0);
        check_value("rst_underflow", 32'(underflow), 32'd0);
        check_value("rst_beam",     {12'd0, beam_y, beam_x}, 32'd0);

        rst_n = 1'b1;
        tick(); tick(); tick();
        check_value("idle_blank",    32'(vga_blank),    32'd1);
        check_value("idle_line_req", 32'(bus.line_req), 32'd0);

        // Enable with immediate ack: PRIME, then RUN from (0,0)
        enable = 1'b1;
        tick();
        check_value("prime_req",    32'(bus.line_req), 32'd1);
        check_value("prime_line_y", 32'(bus.line_y),   32'd0);
        tick();
        check_value("first_frame_start", 32'(frame_start), 32'd1);
        check_value("first_pix_rd",      32'(bus.pix_rd),  32'd1);
        tick();
        check_value("blank_before_latency", 32'(vga_blank), 32'd1);
        tick();
        check_value("first_blank", 32'(vga_blank), 32'd0);
        check_value("first_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h0010_20A5);

        // hsync: 3 low cycles starting at hcnt 10, seen 2 cycles later
        wait_beam(0, 1, "wait_line1");
        lows = 0; first_x = -1;
        for (int i = 0; i < HT; i++) begin
            if (vga_hsync == 1'b0) begin
                if (first_x < 0) first_x = int'(beam_x);
                lows++;
            end
            tick();
        end
        check_value("hsync_low_cycles", 32'(lows), 32'd3);
        check_value("hsync_first_x", 32'(first_x), 32'd12);

        // Frame period
        wait_frame("wait_frame_a");
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!frame_start && cnt < 400);
        check_value("frame_period", 32'(cnt), 32'(HT * VT));

        // vsync: lines 7..8 low, first seen at (2,7)
        lows = 0; seen = 1'b0; first_x = 0; first_y = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (vga_vsync == 1'b0) begin
                if (!seen) begin
                    first_x = int'(beam_x);
                    first_y = int'(beam_y);
                    seen = 1'b1;
                end
                lows++;
            end
            tick();
        end
        check_value("vsync_low_cycles", 32'(lows), 32'd32);
        check_value("vsync_first_y", 32'(first_y), 32'd7);
        check_value("vsync_first_x", 32'(first_x), 32'd2);

        // Ack delayed 5 cycles: requests at hcnt 8 of lines 0..4 and 10 only
        ack_delay = 5;
        n_req = 0; n_cyc = 0; bad = 0; prev_req = 1'b0;
        for (int i = 0; i < HT * VT; i++) begin
            if (bus.line_req) begin
                n_cyc++;
                if (!prev_req) begin
                    n_req++;
                    if (int'(beam_x) != HV) bad++;
                    if (int'(bus.line_y) != (int'(beam_y) + 1) % VT) bad++;
                end
            end
            prev_req = bus.line_req;
            tick();
        end
        ack_delay = 0;
        check_value("delay_req_count", 32'(n_req), 32'd6);
        check_value("delay_req_cycles", 32'(n_cyc), 32'd36);
        check_value("delay_req_pos_err", 32'(bad), 32'd0);
        check_value("delay_underflow", 32'(underflow), 32'd0);

        // Ack withheld for line 3
        ack_mode = 1; target_y = 3;
        wait_beam(HV, 2, "wait_req3");
        check_value("req3_line_y", 32'(bus.line_y), 32'd3);
        wait_beam(HT - 1, 2, "wait_deadline3");
        check_value("req3_held_at_deadline", 32'(bus.line_req), 32'd1);
        tick();
        ack_mode = 0;
        check_value("req3_dropped", 32'(bus.line_req), 32'd0);
        check_value("underflow_set", 32'(underflow), 32'd1);
        bad_rd = 0; bad_out = 0;
        for (int i = 0; i < HV + 2; i++) begin
            if (i < HV && bus.pix_rd) bad_rd++;
            if (i >= 2 && (vga_blank || vga_r != 8'd0 || vga_g != 8'd0 || vga_b != 8'd0)) bad_out++;
            tick();
        end
        check_value("bad_line_pix_rd", 32'(bad_rd), 32'd0);
        check_value("bad_line_output", 32'(bad_out), 32'd0);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check_value("underflow_cleared", 32'(underflow), 32'd0);
        wait_beam(0, 4, "wait_line4");
        check_value("line4_pix_rd", 32'(bus.pix_rd), 32'd1);

        // Ack exactly in the deadline cycle for line 5
        ack_mode = 2; target_y = 5;
        tick(); tick();
        check_value("line4_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h0010_24A5);
        wait_beam(HT - 1, 4, "wait_deadline5");
        check_value("req5_at_deadline", 32'(bus.line_req), 32'd1);
        tick();
        ack_mode = 0;
        check_value("deadline_ack_no_underflow", 32'(underflow), 32'd0);
        check_value("line5_pix_rd", 32'(bus.pix_rd), 32'd1);
        tick(); tick();
        check_value("line5_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h0010_25A5);

        // Underflow coincident with clear: set wins
        ack_mode = 1; target_y = 1;
        wait_beam(HT - 1, 0, "wait_deadline1");
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        ack_mode = 0;
        check_value("set_beats_clear", 32'(underflow), 32'd1);

        // enable drop mid-frame: finish frame, skip line-0 request, go IDLE
        wait_beam(0, 2, "wait_line2");
        enable = 1'b0;
        wait_beam(HV, VT - 1, "wait_last_line");
        check_value("no_line0_req", 32'(bus.line_req), 32'd0);
        wait_beam(HT - 1, VT - 1, "wait_frame_end");
        tick();
        check_value("idle_no_frame_start", 32'(frame_start), 32'd0);
        tick(); tick(); tick(); tick();
        check_value("idle_beam_held", {12'd0, beam_y, beam_x}, 32'd0);
        check_value("idle_blank_held", 32'(vga_blank), 32'd1);
        check_value("idle_no_req", 32'(bus.line_req), 32'd0);
        enable = 1'b1;
        tick();
        check_value("reprime_req", 32'(bus.line_req), 32'd1);
        check_value("reprime_line_y", 32'(bus.line_y), 32'd0);

        // Reset in the middle of a pending request
        wait_beam(0, 1, "wait_rerun");
        ack_mode = 1; target_y = 2;
        wait_beam(HV + 2, 1, "wait_pending");
        check_value("pending_before_reset", 32'(bus.line_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("midrst_line_req", 32'(bus.line_req), 32'd0);
        check_value("midrst_beam", {12'd0, beam_y, beam_x}, 32'd0);
        check_value("midrst_blank", 32'(vga_blank), 32'd1);
        check_value("midrst_syncs", {30'd0, vga_hsync, vga_vsync}, 32'd3);
        check_value("midrst_underflow", 32'(underflow), 32'd0);
        check_value("midrst_pix_rd", 32'(bus.pix_rd), 32'd0);
        ack_mode = 0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_value("post_rst_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
